// File: rtl/branch_ctrl.sv
//------------------------------------------------------------------------------
// branch_ctrl : execute-stage branch decision, registered one-cycle taken flag.
// Optional macro BRANCH_FLAGS_EN adds a registered {lt_u, lt_s, eq} debug port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [2:0]      b_control,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            branch_sel,
  output logic            valid_out,
`ifdef BRANCH_FLAGS_EN
  output logic [2:0]      flags,
`endif
  output logic            illegal
);

  localparam logic [2:0] BC_NONE = 3'b000;
  localparam logic [2:0] BC_BEQ  = 3'b001;
  localparam logic [2:0] BC_BNE  = 3'b010;
  localparam logic [2:0] BC_BLT  = 3'b011;
  localparam logic [2:0] BC_BGE  = 3'b100;
  localparam logic [2:0] BC_BLTU = 3'b101;
  localparam logic [2:0] BC_BGEU = 3'b110;
  localparam logic [2:0] BC_JUMP = 3'b111;

  logic eq;
  logic lt_s;
  logic lt_u;
  logic cond;

  // $signed compare is a true two's-complement compare, so full-range operands cannot overflow.
  assign eq   = (r1 == r2);
  assign lt_u = (r1 < r2);
  assign lt_s = ($signed(r1) < $signed(r2));

  always_comb begin
    cond = 1'b0;
    case (b_control)
      BC_NONE: cond = 1'b0;
      BC_BEQ:  cond = eq;
      BC_BNE:  cond = ~eq;
      BC_BLT:  cond = lt_s;
      BC_BGE:  cond = ~lt_s;
      BC_BLTU: cond = lt_u;
      BC_BGEU: cond = ~lt_u;
      BC_JUMP: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // Gating with valid_in keeps an undefined b_control on idle cycles away from branch_sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_sel <= 1'b0;
      valid_out  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      branch_sel <= valid_in & cond;
      valid_out  <= valid_in;
      illegal    <= valid_in & (b_control == BC_NONE);
    end
  end

`ifdef BRANCH_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 3'b000;
    end else begin
      flags <= {lt_u, lt_s, eq};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
//------------------------------------------------------------------------------
// tb_branch_ctrl : directed vectors with a queue-based scoreboard for branch_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  b_control;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        branch_sel;
  logic        valid_out;
  logic        illegal;
`ifdef BRANCH_FLAGS_EN
  logic [2:0]  flags;
`endif

  typedef struct {
    int         id;
    logic       sel;
    logic       vo;
    logic       ill;
    logic [2:0] flg;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   vec_id     = 0;

  branch_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .b_control  (b_control),
    .r1         (r1),
    .r2         (r2),
    .branch_sel (branch_sel),
    .valid_out  (valid_out),
`ifdef BRANCH_FLAGS_EN
    .flags      (flags),
`endif
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Monitor: every clocked cycle presents a result; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (branch_sel === e.sel) && (valid_out === e.vo) && (illegal === e.ill);
`ifdef BRANCH_FLAGS_EN
      ok = ok && (flags === e.flg);
`endif
      compared++;
      if (!ok) begin
        mismatched++;
`ifdef BRANCH_FLAGS_EN
        $display("FAIL vec%0d: got sel=%b vo=%b ill=%b flags=%b, expected sel=%b vo=%b ill=%b flags=%b",
                 e.id, branch_sel, valid_out, illegal, flags, e.sel, e.vo, e.ill, e.flg);
`else
        $display("FAIL vec%0d: got sel=%b vo=%b ill=%b, expected sel=%b vo=%b ill=%b",
                 e.id, branch_sel, valid_out, illegal, e.sel, e.vo, e.ill);
`endif
      end
    end
  end

  task automatic apply(input logic r, input logic v, input logic [2:0] bc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic es, input logic ev, input logic ei,
                       input logic [2:0] ef);
    exp_t e;
    rst       = r;
    valid_in  = v;
    b_control = bc;
    r1        = a;
    r2        = b;
    @(posedge clk);
    e.id  = vec_id;
    e.sel = es;
    e.vo  = ev;
    e.ill = ei;
    e.flg = ef;
    exp_q.push_back(e);
    vec_id++;
    #1;
  endtask

  initial begin
    logic [2:0] bc_x;
    bc_x = 3'bxxx;
    // rst val bc      r1            r2            sel vo ill flags
    apply(1, 1, 3'b111, 32'h0,        32'h0,        0, 0, 0, 3'b000);
    apply(1, 1, 3'b111, 32'h0,        32'h0,        0, 0, 0, 3'b000);
    apply(0, 1, 3'b111, 32'h0,        32'h0,        1, 1, 0, 3'b001);
    // equality
    apply(0, 1, 3'b001, 32'hF0000000, 32'hF0000000, 1, 1, 0, 3'b001);
    apply(0, 1, 3'b010, 32'hF0000000, 32'hF0000000, 0, 1, 0, 3'b001);
    apply(0, 1, 3'b010, 32'hF0000000, 32'hF0000001, 1, 1, 0, 3'b110);
    apply(0, 1, 3'b001, 32'hF0000000, 32'hF0000001, 0, 1, 0, 3'b110);
    // signed
    apply(0, 1, 3'b011, 32'hF0000000, 32'hF0000001, 1, 1, 0, 3'b110);
    apply(0, 1, 3'b100, 32'hF0000000, 32'hF0000001, 0, 1, 0, 3'b110);
    apply(0, 1, 3'b111, 32'hF0000000, 32'hF0000001, 1, 1, 0, 3'b110);
    apply(0, 1, 3'b100, 32'hF0000000, 32'hFFFFFFFF, 0, 1, 0, 3'b110);
    apply(0, 1, 3'b100, 32'h7FFFFFFF, 32'h80000000, 1, 1, 0, 3'b100);
    apply(0, 1, 3'b011, 32'h7FFFFFFF, 32'h80000000, 0, 1, 0, 3'b100);
    apply(0, 1, 3'b100, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0, 3'b010);
    // unsigned
    apply(0, 1, 3'b101, 32'hF0000000, 32'hFFFFFFFF, 1, 1, 0, 3'b110);
    apply(0, 1, 3'b110, 32'hF0000000, 32'hFFFFFFFF, 0, 1, 0, 3'b110);
    apply(0, 1, 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 3'b001);
    apply(0, 1, 3'b101, 32'h7FFFFFFF, 32'h80000000, 1, 1, 0, 3'b100);
    apply(0, 1, 3'b110, 32'h00000000, 32'h00000001, 0, 1, 0, 3'b110);
    // valid / illegal
    apply(0, 0, 3'b111, 32'h00000001, 32'h00000002, 0, 0, 0, 3'b110);
    apply(0, 0, bc_x,   32'h00000005, 32'h00000005, 0, 0, 0, 3'b001);
    apply(0, 1, 3'b000, 32'h00000005, 32'h00000005, 0, 1, 1, 3'b001);
    // back-to-back
    apply(0, 1, 3'b001, 32'h00000005, 32'h00000005, 1, 1, 0, 3'b001);
    apply(0, 1, 3'b010, 32'h00000005, 32'h00000005, 0, 1, 0, 3'b001);
    apply(0, 1, 3'b001, 32'h00000005, 32'h00000005, 1, 1, 0, 3'b001);
    apply(0, 1, 3'b010, 32'h00000005, 32'h00000005, 0, 1, 0, 3'b001);
    // reset mid-stream discards the in-flight decision
    apply(0, 1, 3'b111, 32'h00000003, 32'h00000004, 1, 1, 0, 3'b110);
    apply(1, 1, 3'b111, 32'h00000003, 32'h00000004, 0, 0, 0, 3'b000);
    apply(0, 1, 3'b000, 32'h00000003, 32'h00000004, 0, 1, 1, 3'b110);
    apply(0, 0, 3'b000, 32'h00000003, 32'h00000004, 0, 0, 0, 3'b110);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
